// File: rtl/dma_arbiter_if.sv
// dma_arbiter_if: requester, UART DMA engine and response signals of the DMA arbiter.
// master is the arbiter's view; slave is the view of the requesters plus engine around it.
interface dma_arbiter_if #(
    parameter int N_REQ  = 2,
    parameter int ADDR_W = 16,
    parameter int DAT_W  = 288
);
    logic [N_REQ-1:0]        req_valid, req_we, req_ready, rsp_done;
    logic [N_REQ*ADDR_W-1:0] req_addr;
    logic [N_REQ*DAT_W-1:0]  req_dat;
    logic                    dma_valid, dma_we, dma_busy, dma_rvalid, timeout_err;
    logic [ADDR_W-1:0]       dma_addr;
    logic [DAT_W-1:0]        dma_dat, dma_rdat, rsp_dat;
    modport master (
        input  req_valid, req_we, req_addr, req_dat, dma_busy, dma_rvalid, dma_rdat,
        output req_ready, dma_valid, dma_we, dma_addr, dma_dat, rsp_done, rsp_dat, timeout_err
    );
    modport slave (
        output req_valid, req_we, req_addr, req_dat, dma_busy, dma_rvalid, dma_rdat,
        input  req_ready, dma_valid, dma_we, dma_addr, dma_dat, rsp_done, rsp_dat, timeout_err
    );
endinterface

// File: rtl/dma_arbiter.sv
// dma_arbiter: round-robin arbiter feeding one outstanding transfer at a time to a UART DMA engine,
// with read-data capture and a sticky watchdog that forces completion of a stuck transfer.
module dma_arbiter #(
    parameter int N_REQ       = 2,
    parameter int ADDR_W      = 16,
    parameter int DAT_W       = 288,
    parameter int TIMEOUT_CYC = 1 << 22
) (
    input logic           clk,
    input logic           reset,
    dma_arbiter_if.master bus
);
    localparam int GW = N_REQ > 1 ? $clog2(N_REQ) : 1;
    localparam int WW = $clog2(TIMEOUT_CYC + 1);
    typedef enum logic [2:0] {IDLE, ISSUE, WAIT_BUSY, WAIT_DONE, COMPLETE} state_e;
    state_e            state_q, state_d;
    logic [GW-1:0]     rr_q, rr_d, gnt_q, gnt_d, pick, idx;
    logic              we_q, we_d, to_q, to_d, sel_we, expired;
    logic [ADDR_W-1:0] addr_q, addr_d, sel_addr;
    logic [DAT_W-1:0]  dat_q, dat_d, rdat_q, rdat_d, sel_dat;
    logic [WW-1:0]     wd_q, wd_d;

    // Scan downwards so the requester closest to rr_q wins.
    always_comb begin
        pick = '0;
        idx = '0;
        sel_we = 1'b0;
        sel_addr = '0;
        sel_dat = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            idx = GW'((int'(rr_q) + k) % N_REQ);
            if (bus.req_valid[idx]) pick = idx;
        end
        for (int i = 0; i < N_REQ; i++)
            if (GW'(i) == pick) begin
                sel_we = bus.req_we[i];
                sel_addr = bus.req_addr[i*ADDR_W +: ADDR_W];
                sel_dat = bus.req_dat[i*DAT_W +: DAT_W];
            end
    end

    assign expired = wd_q == WW'(TIMEOUT_CYC - 1);

    always_comb begin
        state_d = state_q;
        rr_d = rr_q;
        gnt_d = gnt_q;
        we_d = we_q;
        addr_d = addr_q;
        dat_d = dat_q;
        rdat_d = rdat_q;
        to_d = to_q;
        wd_d = state_q == ISSUE ? '0 : (state_q == WAIT_BUSY || state_q == WAIT_DONE) ? wd_q + WW'(1) : wd_q;
        case (state_q)
            IDLE: if (|bus.req_valid) begin
                state_d = ISSUE;
                gnt_d = pick;
                rr_d = pick == GW'(N_REQ - 1) ? '0 : pick + GW'(1);
                we_d = sel_we;
                addr_d = sel_addr;
                dat_d = sel_dat;
            end
            ISSUE: state_d = WAIT_BUSY;
            WAIT_BUSY: if (expired) begin
                to_d = 1'b1;
                state_d = COMPLETE;
            end else if (bus.dma_busy) state_d = WAIT_DONE;
            WAIT_DONE: if (expired) begin
                to_d = 1'b1;
                state_d = COMPLETE;
            end else begin
                if (bus.dma_rvalid && !we_q) rdat_d = bus.dma_rdat;
                if (!bus.dma_busy) state_d = COMPLETE;
            end
            COMPLETE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            state_q <= IDLE;
            rr_q <= '0;
            gnt_q <= '0;
            we_q <= 1'b0;
            addr_q <= '0;
            dat_q <= '0;
            rdat_q <= '0;
            to_q <= 1'b0;
            wd_q <= '0;
        end else begin
            state_q <= state_d;
            rr_q <= rr_d;
            gnt_q <= gnt_d;
            we_q <= we_d;
            addr_q <= addr_d;
            dat_q <= dat_d;
            rdat_q <= rdat_d;
            to_q <= to_d;
            wd_q <= wd_d;
        end

    assign bus.dma_valid = state_q == ISSUE;
    assign bus.req_ready = state_q == ISSUE ? N_REQ'(1) << gnt_q : '0;
    assign bus.rsp_done = state_q == COMPLETE ? N_REQ'(1) << gnt_q : '0;
    assign bus.dma_we = we_q;
    assign bus.dma_addr = addr_q;
    assign bus.dma_dat = dat_q;
    assign bus.rsp_dat = rdat_q;
    assign bus.timeout_err = to_q;
endmodule

// File: doc/dma_arbiter.md
DMA_ARBITER -- requirements
Module: dma_arbiter

Interface
REQ-001 Parameters (name, default, meaning): N_REQ, 2, requester count; ADDR_W, 16, host address width; DAT_W, 288, payload width (4x4x18); TIMEOUT_CYC, 2^22, watchdog limit in clk cycles.
REQ-002 clk  in  1  single clock, all flops rising-edge.
REQ-003 reset  in  1  asynchronous, active-high; all state cleared immediately while high.
REQ-004 req_valid  in  N_REQ  per-requester request; held until req_ready.
REQ-005 req_we  in  N_REQ  1=write to host, 0=read from host.
REQ-006 req_addr  in  N_REQ*ADDR_W  per-requester host address, slice i at [i*ADDR_W +: ADDR_W].
REQ-007 req_dat  in  N_REQ*DAT_W  per-requester write payload.
REQ-008 req_ready  out  N_REQ  one-cycle accept pulse to the granted requester.
REQ-009 dma_valid  out  1  one-cycle issue pulse to the UART DMA engine; dma_we, dma_addr[ADDR_W], dma_dat[DAT_W] valid with it.
REQ-010 dma_busy  in  1  engine busy flag.
REQ-011 dma_rvalid  in  1  engine read-data valid; dma_rdat  in  DAT_W  read payload.
REQ-012 rsp_done  out  N_REQ  one-cycle completion pulse to owner of the transfer.
REQ-013 rsp_dat  out  DAT_W  captured read payload, valid with rsp_done of a read.
REQ-014 timeout_err  out  1  sticky watchdog flag.

Function
REQ-015 States SHALL be IDLE, ISSUE, WAIT_BUSY, WAIT_DONE, COMPLETE; one transfer outstanding at a time.
REQ-016 IDLE: if any req_valid, grant chosen by round-robin starting at rr_ptr; latch grant index, we, addr, dat; go ISSUE next cycle.
REQ-017 rr_ptr SHALL advance to (grant+1) mod N_REQ on each grant; reset value 0.
REQ-018 ISSUE (exactly one cycle): dma_valid=1, req_ready[grant]=1; go WAIT_BUSY.
REQ-019 WAIT_BUSY: stay until dma_busy=1, then WAIT_DONE.
REQ-020 WAIT_DONE: when dma_rvalid=1 and latched we=0, capture dma_rdat into rsp_dat; when dma_busy=0, go COMPLETE.
REQ-021 COMPLETE (one cycle): rsp_done[grant]=1; go IDLE; earliest next ISSUE 2 cycles later (IDLE then ISSUE).
REQ-022 dma_rvalid during a write, or outside WAIT_DONE, SHALL be ignored; rsp_dat unchanged.
REQ-023 Watchdog counter SHALL clear on ISSUE, increment each cycle in WAIT_BUSY/WAIT_DONE; at TIMEOUT_CYC set timeout_err=1 and go COMPLETE (rsp_done still pulsed, rsp_dat not updated).
REQ-024 timeout_err SHALL remain 1 until reset; arbitration continues normally afterwards.
REQ-025 req_valid changes outside IDLE SHALL NOT affect the transfer in flight; deasserted requests are never granted.
REQ-026 Latched payload SHALL drive dma_we/addr/dat stable from ISSUE through COMPLETE; requester may change req_* after req_ready.
REQ-027 At most one bit of req_ready and of rsp_done SHALL be set in any cycle.

Reset
REQ-028 While reset=1: state IDLE, rr_ptr=0, dma_valid=0, req_ready=0, rsp_done=0, rsp_dat=0, timeout_err=0, latched payload=0, watchdog=0.
REQ-029 Reset mid-transfer SHALL abandon it without rsp_done; no dma_valid in the first cycle after release.

Verification
REQ-030 Single write: req0 valid, we=1, addr=0x0042, dat=pattern -> one dma_valid carrying same fields, req_ready[0] same cycle, rsp_done[0] one cycle after dma_busy falls.
REQ-031 Single read: req1 read addr=0x0010, engine returns dma_rdat=0xA5 repeated -> rsp_done[1] with rsp_dat=0xA5 pattern.
REQ-032 Contention: both valid continuously, 4 transfers -> grants 0,1,0,1; never two outstanding dma_valid without intervening busy fall.
REQ-033 Stuck engine: dma_busy never rises, TIMEOUT_CYC=16 -> timeout_err=1 and rsp_done[grant] 16+1 cycles after ISSUE; next request still served.
REQ-034 Reset asserted during WAIT_DONE of a read -> all outputs 0 asynchronously, no rsp_done, rr_ptr=0.
REQ-035 Stray dma_rvalid during a write transfer -> rsp_dat unchanged.
